// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one UART transmitter.
// Optional grant stall timeout is enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 arb_busy,
  output logic                 timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gidx;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] next_ptr;
  logic          pick_found;
  logic          last_q;
  logic          valid_g;
  logic          accept;
  logic          msg_end;
  logic          revoke;

  assign valid_g  = req_valid[gidx];
  assign req_ready = (state == SEND && !tx_busy) ? grant : '0;
  assign accept   = valid_g && req_ready[gidx];
  assign msg_end  = (state == WAIT_DONE) && tx_done && last_q;
  assign next_ptr = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);

  // Circular scan from rr_ptr for the first requester with valid high
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req_valid[j]) begin
        pick_found = 1'b1;
        pick_idx   = j[IW-1:0];
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state: lock onto one owner until its last byte completes
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (pick_found) state_d = SEND;
      end
      SEND: begin
        if (accept)      state_d = WAIT_DONE;
        else if (revoke) state_d = IDLE;
      end
      WAIT_DONE: begin
        if (tx_done) state_d = last_q ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, pointer and transmit byte registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant    <= '0;
      gidx     <= '0;
      arb_busy <= 1'b0;
      rr_ptr   <= '0;
      last_q   <= 1'b0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
    end else begin
      tx_start <= accept;
      if (state == IDLE && pick_found) begin
        grant    <= NUM_REQ'(1) << pick_idx;
        gidx     <= pick_idx;
        arb_busy <= 1'b1;
      end
      if (accept) begin
        tx_data <= req_data[8*gidx +: 8];
        last_q  <= req_last[gidx];
      end
      if (msg_end || revoke) begin
        grant    <= '0;
        arb_busy <= 1'b0;
        rr_ptr   <= next_ptr;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [19:0] TO_LIM = 20'(TIMEOUT_CYC);

  logic [19:0] to_cnt;

  assign revoke = (state == SEND) && !valid_g &&
                  (to_cnt == TO_LIM - 20'd1);

  // Stall counter: counts SEND cycles with the owner's valid low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= revoke;
      if ((state_d == SEND && state != SEND) || accept)
        to_cnt <= '0;
      else if (state == SEND && !valid_g)
        to_cnt <= to_cnt + 20'd1;
    end
  end
`else
  logic unused_cfg;

  assign revoke      = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter.
// Transmitter is modelled as a fixed-length frame ending in a done pulse.
module tb_uart_tx_arbiter;

  localparam int N     = 2;
  localparam int FRAME = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_last = '0;
  logic [15:0]  req_data = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0] grant;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_done = 1'b0;
  logic         tx_busy;
  logic         arb_busy;
  logic         timeout_err;

  logic busy_m = 1'b0;
  logic hold_busy = 1'b0;
  int   fcnt = 0;
  logic prev_start = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [9:0] exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .tx_busy    (tx_busy),
    .grant      (grant),
    .arb_busy   (arb_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign tx_busy = busy_m | hold_busy;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Transmitter model: frame of FRAME cycles, done pulse at the end
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (tx_start) begin
      busy_m <= 1'b1;
      fcnt   <= FRAME;
    end else if (busy_m) begin
      if (fcnt == 1) begin
        busy_m  <= 1'b0;
        tx_done <= 1'b1;
      end
      fcnt <= fcnt - 1;
    end
  end

  // Requester model: present queue heads, pop on handshake
  always @(posedge clk) begin
    logic [8:0] h;
    if (req_valid[0] && req_ready[0] && src0.size() != 0)
      void'(src0.pop_front());
    if (req_valid[1] && req_ready[1] && src1.size() != 0)
      void'(src1.pop_front());
    #1;
    h = (src0.size() != 0) ? src0[0] : 9'h000;
    req_valid[0]   = src0.size() != 0;
    req_last[0]    = h[8];
    req_data[7:0]  = h[7:0];
    h = (src1.size() != 0) ? src1[0] : 9'h000;
    req_valid[1]   = src1.size() != 0;
    req_last[1]    = h[8];
    req_data[15:8] = h[7:0];
  end

  // Scoreboard: every tx_start pops one expected {grant, byte}
  always @(negedge clk) begin
    logic [9:0] e;
    if (tx_start) begin
      check("tx_start_width", prev_start, 0);
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL tx_extra: observed byte %0h expected none", tx_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_byte", tx_data, e[7:0]);
        check("tx_grant", grant, e[9:8]);
      end
    end
    prev_start = tx_start;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_arb_busy"}, arb_busy, 0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_timeout"}, timeout_err, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals(tag);
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || arb_busy || busy_m ||
            src0.size() != 0 || src1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < 500, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no summary expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dn;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    // single message from requester 0
    @(negedge clk);
    src0.push_back({1'b0, 8'h48});
    src0.push_back({1'b1, 8'h49});
    exp_q.push_back({2'b01, 8'h48});
    exp_q.push_back({2'b01, 8'h49});
    @(negedge clk);
    check("t1_grant_early", grant, 0);
    @(negedge clk);
    check("t1_grant", grant, 2'b01);
    check("t1_ready", req_ready, 2'b01);
    check("t1_arb_busy", arb_busy, 1);
    dn = 0;
    n = 0;
    while (dn < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (tx_done) dn++;
    end
    check("t1_dones", dn, 2);
    check("t1_busy_at_done", arb_busy, 1);
    @(negedge clk);
    check("t1_busy_after", arb_busy, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // contention right after reset
    do_reset("t2_rst");
    src0.push_back({1'b0, 8'hA0});
    src0.push_back({1'b0, 8'hA1});
    src0.push_back({1'b1, 8'hA2});
    src1.push_back({1'b0, 8'hB0});
    src1.push_back({1'b1, 8'hB1});
    exp_q.push_back({2'b01, 8'hA0});
    exp_q.push_back({2'b01, 8'hA1});
    exp_q.push_back({2'b01, 8'hA2});
    exp_q.push_back({2'b10, 8'hB0});
    exp_q.push_back({2'b10, 8'hB1});
    wait_drain("t2_drain");

    // round-robin fairness with continuous one-byte messages
    src0.push_back({1'b1, 8'hC0});
    src0.push_back({1'b1, 8'hC1});
    src1.push_back({1'b1, 8'hD0});
    src1.push_back({1'b1, 8'hD1});
    exp_q.push_back({2'b01, 8'hC0});
    exp_q.push_back({2'b10, 8'hD0});
    exp_q.push_back({2'b01, 8'hC1});
    exp_q.push_back({2'b10, 8'hD1});
    wait_drain("t3_drain");

    // backpressure from a busy transmitter
    hold_busy = 1'b1;
    src0.push_back({1'b1, 8'hE0});
    exp_q.push_back({2'b01, 8'hE0});
    repeat (8) begin
      @(negedge clk);
      check("t4_ready_held", req_ready, 0);
      check("t4_no_start", tx_start, 0);
    end
    check("t4_grant", grant, 2'b01);
    hold_busy = 1'b0;
    #1;
    check("t4_ready_rise", req_ready, 2'b01);
    wait_drain("t4_drain");

    // reset in WAIT_DONE after the first of three bytes
    do_reset("t5_rst");
    src0.push_back({1'b0, 8'hF0});
    src0.push_back({1'b0, 8'hF1});
    src0.push_back({1'b1, 8'hF2});
    exp_q.push_back({2'b01, 8'hF0});
    exp_q.push_back({2'b01, 8'hF1});
    exp_q.push_back({2'b01, 8'hF2});
    n = 0;
    while (!tx_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_first_start", tx_start, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("t5_mid");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_regrant", grant, 2'b01);
    check("t5_rebusy", arb_busy, 1);
    wait_drain("t5_drain");

    // owner stalls mid-message while requester 1 waits
    do_reset("t6_rst");
    src0.push_back({1'b0, 8'h60});
    src1.push_back({1'b1, 8'h61});
    exp_q.push_back({2'b01, 8'h60});
`ifdef ARB_TIMEOUT_EN
    exp_q.push_back({2'b10, 8'h61});
`endif
    n = 0;
    while (!tx_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_done", tx_done, 1);
`ifdef ARB_TIMEOUT_EN
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout_err && n < 100);
    check("t6_timeout_cycles", n, 17);
    check("t6_grant_revoked", grant, 0);
    @(negedge clk);
    check("t6_timeout_pulse", timeout_err, 0);
    check("t6_grant_req1", grant, 2'b10);
    wait_drain("t6_drain");
`else
    repeat (40) begin
      @(negedge clk);
      check("t6_grant_kept", grant, 2'b01);
      check("t6_no_timeout", timeout_err, 0);
    end
`endif

    check("final_sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
